// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch predictor with 2-bit saturating
// counters and a stored branch target per entry.
// Optional build macro: BP_TAG_CHECK_EN. When it is defined, entries carry
// a tag and a hit needs a tag match. When it is undefined, no tags are
// stored and PCs that share an index also share an entry.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        prediction,
    output logic [31:0] predicted_target,
    output logic [1:0]  pred_state,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0]       valid_q;
    logic [ENTRIES-1:0][31:0] target_q;
    logic [ENTRIES-1:0][1:0]  ctr_q;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] u_idx;
    logic             f_tag_ok;
    logic             u_tag_ok;
    logic             f_hit;
    logic             u_hit;
    logic [1:0]       u_ctr;
    logic [1:0]       u_ctr_nxt;

    // Word-aligned PCs: the two low bits never take part in lookup.
    logic unused_lsb;
    assign unused_lsb = ^{fetch_pc[1:0], update_pc[1:0]};

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign u_idx = update_pc[IDX_W+1:2];

`ifdef BP_TAG_CHECK_EN
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;

    assign f_tag_ok = (tag_q[f_idx] == fetch_pc[31:IDX_W+2]);
    assign u_tag_ok = (tag_q[u_idx] == update_pc[31:IDX_W+2]);

    // Tag is written only on allocation; it is meaningless while valid=0,
    // so it needs no reset.
    always_ff @(posedge clock) begin
        if (reset && update_valid && !u_hit && update_taken)
            tag_q[u_idx] <= update_pc[31:IDX_W+2];
    end
`else
    // Without tags the upper PC bits are intentionally ignored (aliasing).
    logic unused_tag;
    assign unused_tag = ^{fetch_pc[31:IDX_W+2], update_pc[31:IDX_W+2]};
    assign f_tag_ok   = 1'b1;
    assign u_tag_ok   = 1'b1;
`endif

    assign f_hit = valid_q[f_idx] & f_tag_ok;
    assign u_hit = valid_q[u_idx] & u_tag_ok;

    // Lookup reads the registered table, so a same-cycle update is only
    // visible from the next cycle.
    always_comb begin
        prediction       = f_hit & ctr_q[f_idx][1];
        predicted_target = prediction ? target_q[f_idx] : 32'h0;
        pred_state       = valid_q[f_idx] ? ctr_q[f_idx] : 2'b00;
    end

    // Saturating counter step for the entry being updated.
    always_comb begin
        u_ctr     = ctr_q[u_idx];
        u_ctr_nxt = u_ctr;
        if (update_taken) begin
            if (u_ctr != 2'b11) u_ctr_nxt = u_ctr + 2'b01;
        end else begin
            if (u_ctr != 2'b00) u_ctr_nxt = u_ctr - 2'b01;
        end
    end

    // Table update: reset wins over any update presented in the same cycle;
    // a hit trains the counter, a taken miss allocates, a not-taken miss is
    // dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (update_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_nxt;
                if (update_taken) target_q[u_idx] <= update_target;
            end else if (update_taken) begin
                valid_q[u_idx]  <= 1'b1;
                target_q[u_idx] <= update_target;
                ctr_q[u_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios plus randomized traffic checked
// against a table model built directly from the predictor's rules.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        prediction;
    logic [31:0] predicted_target;
    logic [1:0]  pred_state;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clock(clk), .reset(reset), .fetch_pc(fetch_pc),
        .prediction(prediction), .predicted_target(predicted_target),
        .pred_state(pred_state), .update_valid(update_valid),
        .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target)
    );

    always #5 clk = ~clk;

    // Reference model: one record per index.
    bit          mv[ENTRIES];
    int unsigned mt[ENTRIES];
    logic [31:0] mg[ENTRIES];
    int          mc[ENTRIES];

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
`ifdef BP_TAG_CHECK_EN
        return mv[m_idx(pc)] && (mt[m_idx(pc)] == m_tag(pc));
`else
        return mv[m_idx(pc)];
`endif
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return m_hit(pc) && (mc[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] pc);
        return m_pred(pc) ? mg[m_idx(pc)] : 32'h0;
    endfunction

    function automatic logic [1:0] m_state(input logic [31:0] pc);
        return mv[m_idx(pc)] ? 2'(mc[m_idx(pc)]) : 2'b00;
    endfunction

    task automatic model_step(input logic rst, input logic uv, input logic [31:0] pc,
                              input logic tk, input logic [31:0] tg);
        int i;
        i = m_idx(pc);
        if (!rst) begin
            for (int k = 0; k < ENTRIES; k++) begin mv[k] = 0; mc[k] = 1; end
        end else if (uv) begin
            if (m_hit(pc)) begin
                mc[i] = tk ? ((mc[i] + 1 > 3) ? 3 : mc[i] + 1)
                           : ((mc[i] - 1 < 0) ? 0 : mc[i] - 1);
                if (tk) mg[i] = tg;
            end else if (tk) begin
                mv[i] = 1; mt[i] = m_tag(pc); mg[i] = tg; mc[i] = 2;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic uv, input logic [31:0] upc,
                         input logic tk, input logic [31:0] tg, input logic [31:0] fpc);
        reset = rst; update_valid = uv; update_pc = upc;
        update_taken = tk; update_target = tg; fetch_pc = fpc;
    endtask

    // Advance one clock and mirror the edge into the model.
    task automatic tick();
        @(posedge clk);
        model_step(reset, update_valid, update_pc, update_taken, update_target);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] pc;
        drive(0, 1, 32'h40, 1, 32'h100, 32'h40);
        tick(); tick();
        drive(1, 0, 0, 0, 0, 32'h40);
        #2;
        checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", prediction); end
        checks++; if (predicted_target !== 32'h0) begin errors++; $display("FAIL reset_tgt: got %h want 0", predicted_target); end
        checks++; if (pred_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", pred_state); end
        for (int n = 0; n < 8; n++) begin
            pc = $urandom;
            fetch_pc = pc;
            #1;
            checks++;
            if ({prediction, predicted_target, pred_state} !== 35'h0) begin
                errors++; $display("FAIL reset_any pc=%h: got %b/%h/%b want 0/0/00", pc, prediction, predicted_target, pred_state);
            end
        end
    endtask

    task automatic test_alloc();
        drive(1, 1, 32'h40, 1, 32'h100, 32'h0);
        tick();
        drive(1, 0, 0, 0, 0, 32'h40);
        #2;
        checks++; if (prediction !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %0b want 1", prediction); end
        checks++; if (predicted_target !== 32'h100) begin errors++; $display("FAIL alloc_tgt: got %h want 00000100", predicted_target); end
        checks++; if (pred_state !== 2'b10) begin errors++; $display("FAIL alloc_state: got %b want 10", pred_state); end
    endtask

    task automatic test_counter();
        logic [1:0] exp_s [5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        logic       exp_p [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int n = 0; n < 5; n++) begin
            drive(1, 1, 32'h40, (n >= 3), 32'h100, 32'h40);
            tick();
            drive(1, 0, 0, 0, 0, 32'h40);
            #2;
            checks++; if (pred_state !== exp_s[n]) begin errors++; $display("FAIL counter_state[%0d]: got %b want %b", n, pred_state, exp_s[n]); end
            checks++; if (prediction !== exp_p[n]) begin errors++; $display("FAIL counter_pred[%0d]: got %0b want %0b", n, prediction, exp_p[n]); end
        end
    endtask

    task automatic test_alias();
        logic        exp_p;
        logic [31:0] exp_t;
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 32'h40, 1, 32'h100, 32'h0); tick();
        drive(1, 0, 0, 0, 0, 32'h80);
        #2;
`ifdef BP_TAG_CHECK_EN
        exp_p = 1'b0; exp_t = 32'h0;
`else
        exp_p = 1'b1; exp_t = 32'h100;
`endif
        checks++; if (prediction !== exp_p) begin errors++; $display("FAIL alias_pred: got %0b want %0b", prediction, exp_p); end
        checks++; if (predicted_target !== exp_t) begin errors++; $display("FAIL alias_tgt: got %h want %h", predicted_target, exp_t); end
        // Low PC bits are ignored on both ports.
        fetch_pc = 32'h43;
        #1;
        checks++; if (prediction !== 1'b1) begin errors++; $display("FAIL lsb_pred: got %0b want 1", prediction); end
    endtask

    task automatic test_same_cycle();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 32'h42, 1, 32'h200, 32'h40);
        #2;
        checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL bypass_now: got %0b want 0", prediction); end
        tick();
        drive(1, 0, 0, 0, 0, 32'h40);
        #2;
        checks++; if (prediction !== 1'b1) begin errors++; $display("FAIL bypass_next: got %0b want 1", prediction); end
        checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL bypass_tgt: got %h want 00000200", predicted_target); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pcs [3] = '{32'h40, 32'h44, 32'h48};
        drive(1, 1, 32'h40, 1, 32'h100, 0); tick();
        drive(1, 1, 32'h44, 1, 32'h104, 0); tick();
        drive(1, 0, 0, 0, 0, 32'h44);
        #2;
        checks++; if (prediction !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0b want 1", prediction); end
        drive(0, 1, 32'h48, 1, 32'h108, 0); tick();
        drive(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            fetch_pc = pcs[n];
            #1;
            checks++;
            if (prediction !== 1'b0 || pred_state !== 2'b00) begin
                errors++; $display("FAIL mid_reset pc=%h: got %0b/%b want 0/00", pcs[n], prediction, pred_state);
            end
        end
    endtask

    // Random traffic over a small PC pool so indices collide and tags alias.
    task automatic test_random();
        logic [31:0] upc, fpc;
        for (int n = 0; n < 600; n++) begin
            upc = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            fpc = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) fpc = upc;
            drive(($urandom_range(0, 60) != 0), $urandom_range(0, 1), upc,
                  ($urandom_range(0, 2) != 0), $urandom, fpc);
            #2;
            checks++;
            if (prediction !== m_pred(fpc) || predicted_target !== m_tgt(fpc) || pred_state !== m_state(fpc)) begin
                errors++;
                $display("FAIL random[%0d] pc=%h: got %0b/%h/%b want %0b/%h/%b", n, fpc,
                         prediction, predicted_target, pred_state, m_pred(fpc), m_tgt(fpc), m_state(fpc));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
